// File: rtl/riscv_pkg.sv
// Shared RV32I front-end definitions: architectural widths, the canonical NOP,
// PC stepping, and the fetch buffer entry layout.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] RV_NOP           = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of {pc, instr} entries with flush; the head
// entry is presented combinationally from registered storage.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  wdata,
    output fetch_entry_t  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_pop;

    assign do_pop = pop && !empty;
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign rdata  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    // NOTE: storage is not reset; count/empty gate every read, so contents are don't-care.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch front-end: owns the fetch PC, issues credit-limited in-order
// memory requests, buffers returned words and flushes on redirect.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] new_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   fifo_count;
    logic            fetch_active;
    logic            credit_ok;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    head;
    fetch_entry_t    wr_entry;

    // Every in-flight request owns a buffer slot, so a response can never overflow the FIFO.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < CREDIT_MAX;
    assign imem_req  = fetch_active && credit_ok && !redirect_valid;
    assign imem_addr = fetch_pc;
    assign req_fire  = imem_req && imem_gnt;
    assign new_pc    = redirect_pc & ~XLEN'(3);

    assign push     = imem_rvalid && (discard == '0) && !redirect_valid;
    assign pop      = instr_valid && instr_ready && !redirect_valid;
    assign wr_entry = '{pc: resp_pc, instr: imem_rdata};

    // fetch_active holds off the first request for one cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_active <= 1'b0;
            fetch_pc     <= RESET_PC;
            resp_pc      <= RESET_PC;
            outstanding  <= '0;
            discard      <= '0;
        end else begin
            fetch_active <= 1'b1;
            if (redirect_valid) begin
                // Anything still in flight belongs to the old path and must be dropped.
                fetch_pc    <= new_pc;
                resp_pc     <= new_pc;
                outstanding <= outstanding - CW'(imem_rvalid);
                discard     <= outstanding - CW'(imem_rvalid);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
                outstanding <= outstanding + CW'(req_fire) - CW'(imem_rvalid);
                if (imem_rvalid) begin
                    if (discard != '0) discard <= discard - CW'(1);
                    else               resp_pc <= resp_pc + PC_STEP;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wr_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = instr_valid ? head.instr : RV_NOP;
    assign instr_pc    = instr_valid ? head.pc : '0;

    fifo_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full && !pop));

    outstanding_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
        outstanding <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized checks of instr_fetch_unit against a small in-order
// instruction memory model.
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int grants = 0;
    bit auto_mem = 1'b0;
    int gnt_pct = 100;
    int rd_max = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Memory model: presents due responses in order, then randomly grants.
    task automatic mem_drive();
        pend_t p;
        int    d;
        if (auto_mem) begin
            if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
                p = pend_q.pop_front();
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(p.addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
            imem_gnt = ($urandom_range(99) < gnt_pct);
        end
        #1;
        if (imem_req && imem_gnt) begin
            grants++;
            if (auto_mem) begin
                d = int'($urandom_range(rd_max));
                p.addr = imem_addr;
                p.due  = cyc + 1 + d;
                pend_q.push_back(p);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        auto_mem = 1'b0;
        pend_q.delete();
        grants = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr); end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        vectors++; if (instr !== RV_NOP) begin miscompares++; $display("FAIL reset_instr: got %h expected %h", instr, RV_NOP); end
        vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h expected 00000000", instr_pc); end
    endtask

    task automatic test_zero_wait();
        int first = -1;
        int n = 0;
        logic [31:0] exp_pc = 32'h0;
        do_reset();
        auto_mem = 1'b1; gnt_pct = 100; rd_max = 0; instr_ready = 1'b1;
        for (int s = 0; s < 40 && n < 4; s++) begin
            mem_drive();
            if (instr_valid && first < 0) first = cyc;
            if (instr_valid && instr_ready) begin
                vectors++; if (instr_pc !== exp_pc) begin miscompares++; $display("FAIL zw_pc: got %h expected %h", instr_pc, exp_pc); end
                vectors++; if (instr !== mem_word(exp_pc)) begin miscompares++; $display("FAIL zw_instr: got %h expected %h", instr, mem_word(exp_pc)); end
                exp_pc += 4;
                n++;
            end
            tick();
        end
        vectors++; if (n != 4) begin miscompares++; $display("FAIL zw_timeout: got %0d transfers expected 4", n); end
        vectors++; if (first != 3) begin miscompares++; $display("FAIL zw_latency: got first valid at cycle %0d expected 3", first); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        logic [31:0] exp_pc = 32'h0;
        do_reset();
        auto_mem = 1'b1; gnt_pct = 100; rd_max = 0; instr_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
            mem_drive();
            tick();
        end
        mem_drive();
        vectors++; if (grants != 2) begin miscompares++; $display("FAIL bp_grants: got %0d expected 2", grants); end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL bp_req: got %b expected 0", imem_req); end
        tick();
        instr_ready = 1'b1;
        for (int s = 0; s < 30 && n < 3; s++) begin
            mem_drive();
            if (instr_valid && instr_ready) begin
                vectors++; if (instr_pc !== exp_pc) begin miscompares++; $display("FAIL bp_pc: got %h expected %h", instr_pc, exp_pc); end
                exp_pc += 4;
                n++;
            end
            tick();
        end
        vectors++; if (n != 3) begin miscompares++; $display("FAIL bp_timeout: got %0d transfers expected 3", n); end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        instr_ready = 1'b1;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h10; #1;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rf_req_during_redirect: got %b expected 0", imem_req); end
        tick();
        redirect_valid = 1'b0; #1;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin miscompares++; $display("FAIL rf_req0: got req=%b addr=%h expected req=1 addr=00000010", imem_req, imem_addr); end
        imem_gnt = 1'b1;
        tick();
        #1;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin miscompares++; $display("FAIL rf_req1: got req=%b addr=%h expected req=1 addr=00000014", imem_req, imem_addr); end
        tick();
        imem_gnt = 1'b0; #1;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rf_credit: got %b expected 0", imem_req); end
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        tick();
        redirect_valid = 1'b0; #1;
        vectors++; if (imem_addr !== 32'h100) begin miscompares++; $display("FAIL rf_new_addr: got %h expected 00000100", imem_addr); end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rf_req_blocked: got %b expected 0", imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0010;
        tick();
        #1;
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rf_drop0: got %b expected 0", instr_valid); end
        imem_rdata = 32'hBAD0_0014;
        tick();
        imem_rvalid = 1'b0; #1;
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rf_drop1: got %b expected 0", instr_valid); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin miscompares++; $display("FAIL rf_refetch: got req=%b addr=%h expected req=1 addr=00000100", imem_req, imem_addr); end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = mem_word(32'h100);
        tick();
        imem_rvalid = 1'b0; #1;
        vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== mem_word(32'h100)) begin
            miscompares++; $display("FAIL rf_new_instr: got v=%b pc=%h instr=%h expected v=1 pc=00000100 instr=%h", instr_valid, instr_pc, instr, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        instr_ready = 1'b1;
        tick();
        imem_gnt = 1'b1;
        tick();
        imem_rvalid = 1'b1; imem_rdata = mem_word(32'h0);
        tick();
        imem_gnt = 1'b0; #1;
        vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin miscompares++; $display("FAIL rs_pre: got v=%b pc=%h expected v=1 pc=00000000", instr_valid, instr_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h40; imem_rdata = mem_word(32'h4); #1;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rs_req: got %b expected 0", imem_req); end
        tick();
        redirect_valid = 1'b0; imem_rvalid = 1'b0; #1;
        vectors++; if (instr_valid !== 1'b0 || instr !== RV_NOP || instr_pc !== 32'h0) begin
            miscompares++; $display("FAIL rs_flushed: got v=%b instr=%h pc=%h expected v=0 instr=%h pc=00000000", instr_valid, instr, instr_pc, RV_NOP);
        end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin miscompares++; $display("FAIL rs_refetch: got req=%b addr=%h expected req=1 addr=00000040", imem_req, imem_addr); end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = mem_word(32'h40);
        tick();
        imem_rvalid = 1'b0; #1;
        vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== mem_word(32'h40)) begin
            miscompares++; $display("FAIL rs_discard: got v=%b pc=%h instr=%h expected v=1 pc=00000040 instr=%h", instr_valid, instr_pc, instr, mem_word(32'h40));
        end
    endtask

    task automatic test_random();
        int n = 0;
        int max_out = 0;
        int bad = 0;
        logic [31:0] exp_pc = 32'h0;
        do_reset();
        auto_mem = 1'b1; gnt_pct = 50; rd_max = 5;
        for (int s = 0; s < 30000 && n < 1000; s++) begin
            instr_ready = ($urandom_range(9) < 7);
            mem_drive();
            if (pend_q.size() > max_out) max_out = pend_q.size();
            if (instr_valid && instr_ready) begin
                vectors++;
                if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
                    miscompares++; bad++;
                    if (bad <= 5) $display("FAIL rnd_stream: got pc=%h instr=%h expected pc=%h instr=%h", instr_pc, instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc += 4;
                n++;
            end
            tick();
        end
        vectors++; if (n != 1000) begin miscompares++; $display("FAIL rnd_timeout: got %0d transfers expected 1000", n); end
        vectors++; if (max_out > 2) begin miscompares++; $display("FAIL rnd_outstanding: got max %0d expected at most 2", max_out); end
    endtask

    task automatic test_reset_mid_op();
        int n = 0;
        do_reset();
        auto_mem = 1'b1; gnt_pct = 100; rd_max = 0; instr_ready = 1'b0;
        for (int s = 0; s < 8; s++) begin
            mem_drive();
            tick();
        end
        mem_drive();
        vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin miscompares++; $display("FAIL rm_full: got v=%b pc=%h expected v=1 pc=00000000", instr_valid, instr_pc); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (instr_valid !== 1'b0 || instr !== RV_NOP || instr_pc !== 32'h0) begin
            miscompares++; $display("FAIL rm_outputs: got v=%b instr=%h pc=%h expected v=0 instr=%h pc=00000000", instr_valid, instr, instr_pc, RV_NOP);
        end
        vectors++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL rm_req: got req=%b addr=%h expected req=0 addr=00000000", imem_req, imem_addr); end
        auto_mem = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; pend_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1; cyc = 0;
        auto_mem = 1'b1; instr_ready = 1'b1;
        for (int s = 0; s < 20 && n < 1; s++) begin
            mem_drive();
            if (instr_valid && instr_ready) begin
                vectors++; if (instr_pc !== 32'h0 || instr !== mem_word(32'h0)) begin
                    miscompares++; $display("FAIL rm_refetch: got pc=%h instr=%h expected pc=00000000 instr=%h", instr_pc, instr, mem_word(32'h0));
                end
                n++;
            end
            tick();
        end
        vectors++; if (n != 1) begin miscompares++; $display("FAIL rm_timeout: got %0d transfers expected 1", n); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_redirect_flush();
        test_redirect_same_cycle();
        test_random();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
